// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two byte requesters.
// Each transfer runs IDLE (grant/ACK) -> LAUNCH -> WAIT_DONE (done or timeout) -> GAP -> IDLE.
module uart_tx_arbiter #(
  parameter int unsigned c_TIMEOUT_CYCLES = 10000
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_REQ0_DV,
  input  logic [7:0] i_REQ0_DATA,
  output logic       o_REQ0_ACK,
  input  logic       i_REQ1_DV,
  input  logic [7:0] i_REQ1_DATA,
  output logic       o_REQ1_ACK,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_DATA,
  input  logic       i_TX_ACTIVE,
  input  logic       i_TX_DONE,
  output logic       o_BUSY,
  output logic       o_GRANT,
  output logic       o_TIMEOUT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arbState_t;

  localparam logic [31:0] TimeoutLast = 32'(c_TIMEOUT_CYCLES - 1);

  arbState_t   state_q, state_d;
  logic [7:0]  txData_q, txData_d;
  logic        grant_q, grant_d;
  logic        lastServed_q, lastServed_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        txDv_q, txDv_d;
  logic        timeout_q, timeout_d;
  logic [31:0] timeoutCnt_q, timeoutCnt_d;

  logic anyReq;
  logic grantNow;
  logic grantSel;
  logic timeoutHit;

  // On a tie the requester that was not served last wins; a lone request always wins.
  assign anyReq     = i_REQ0_DV | i_REQ1_DV;
  assign grantNow   = (state_q == IDLE) && !i_TX_ACTIVE && anyReq;
  assign grantSel   = (i_REQ0_DV && i_REQ1_DV) ? ~lastServed_q : i_REQ1_DV;
  assign timeoutHit = (state_q == WAIT_DONE) && !i_TX_DONE && (timeoutCnt_q == TimeoutLast);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q      <= IDLE;
      txData_q     <= 8'h00;
      grant_q      <= 1'b0;
      lastServed_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      txDv_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timeoutCnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      txData_q     <= txData_d;
      grant_q      <= grant_d;
      lastServed_q <= lastServed_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      txDv_q       <= txDv_d;
      timeout_q    <= timeout_d;
      timeoutCnt_q <= timeoutCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grantNow) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (i_TX_DONE || timeoutHit) state_d = GAP;
      GAP:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A done arriving on the last allowed cycle takes priority over the timeout.
  always_comb begin
    txData_d     = txData_q;
    grant_d      = grant_q;
    lastServed_d = lastServed_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    txDv_d       = 1'b0;
    timeout_d    = 1'b0;
    timeoutCnt_d = timeoutCnt_q;
    case (state_q)
      IDLE: begin
        if (grantNow) begin
          grant_d      = grantSel;
          lastServed_d = grantSel;
          ack0_d       = ~grantSel;
          ack1_d       = grantSel;
          txData_d     = grantSel ? i_REQ1_DATA : i_REQ0_DATA;
        end
      end
      LAUNCH: begin
        txDv_d       = 1'b1;
        timeoutCnt_d = 32'd0;
      end
      WAIT_DONE: begin
        if (!i_TX_DONE) begin
          if (timeoutHit) begin
            timeout_d = 1'b1;
          end else begin
            timeoutCnt_d = timeoutCnt_q + 32'd1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign o_REQ0_ACK = ack0_q;
  assign o_REQ1_ACK = ack1_q;
  assign o_TX_DV    = txDv_q;
  assign o_TX_DATA  = txData_q;
  assign o_BUSY     = (state_q != IDLE);
  assign o_GRANT    = grant_q;
  assign o_TIMEOUT  = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter c_TIMEOUT_CYCLES, default 10000, max cycles to wait for i_TX_DONE after launch.
REQ-002 i_CLK  input  1  single clock; all logic on rising edge.
REQ-003 i_RST_N  input  1  asynchronous, active-low reset.
REQ-004 i_REQ0_DV  input  1  requester 0 has a byte; held high until acked.
REQ-005 i_REQ0_DATA  input  8  requester 0 byte; stable while i_REQ0_DV high.
REQ-006 o_REQ0_ACK  output  1  one-cycle pulse: requester 0 byte captured.
REQ-007 i_REQ1_DV  input  1  requester 1 has a byte; held high until acked.
REQ-008 i_REQ1_DATA  input  8  requester 1 byte.
REQ-009 o_REQ1_ACK  output  1  one-cycle pulse: requester 1 byte captured.
REQ-010 o_TX_DV  output  1  one-cycle launch strobe to UART transmitter.
REQ-011 o_TX_DATA  output  8  byte to transmitter; stable from launch until back in IDLE.
REQ-012 i_TX_ACTIVE  input  1  transmitter busy.
REQ-013 i_TX_DONE  input  1  transmitter finished stop bit.
REQ-014 o_BUSY  output  1  high in any state other than IDLE.
REQ-015 o_GRANT  output  1  index of requester currently/last served.
REQ-016 o_TIMEOUT  output  1  one-cycle pulse when a transfer is abandoned.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE, GAP; one-hot or binary at implementer's choice.
REQ-018 IDLE: if i_TX_ACTIVE low and any DV high, select requester, latch its data into o_TX_DATA, pulse its ACK, set o_GRANT, go LAUNCH; else stay.
REQ-019 Arbitration SHALL be round-robin: single request wins; both requesting, the requester not equal to last-served wins.
REQ-020 Last-served pointer SHALL update only on a grant; after reset it is 1, so requester 0 wins the first tie.
REQ-021 IDLE with i_TX_ACTIVE high SHALL not grant (no ACK) regardless of DV.
REQ-022 LAUNCH: o_TX_DV high exactly this one cycle; clear timeout counter; go WAIT_DONE.
REQ-023 WAIT_DONE: on i_TX_DONE high go GAP; else increment 32-bit timeout counter.
REQ-024 When counter reaches c_TIMEOUT_CYCLES-1 without i_TX_DONE, pulse o_TIMEOUT and go GAP; byte is dropped, not retried.
REQ-025 i_TX_DONE and timeout in the same cycle: i_TX_DONE wins, no o_TIMEOUT.
REQ-026 GAP: one cycle, no grant, then IDLE; guarantees ≥1 idle cycle for transmitter between bytes.
REQ-027 Minimum IDLE->IDLE sequence: IDLE(ack) -> LAUNCH -> WAIT_DONE(≥1) -> GAP -> IDLE.
REQ-028 At most one ACK per transfer; ACK0 and ACK1 never high together.
REQ-029 DV dropped by a requester before ACK SHALL be treated as withdrawn, no error.
REQ-030 o_TX_DV, ACKs, o_TIMEOUT SHALL be registered outputs.

Reset
REQ-031 On i_RST_N low, immediately: state IDLE, o_TX_DV 0, o_TX_DATA 0x00, ACKs 0, o_BUSY 0, o_GRANT 0, o_TIMEOUT 0, counter 0, last-served 1.
REQ-032 Reset mid-transfer SHALL abandon the byte with no ACK/TIMEOUT pulses on release.
REQ-033 First grant possible on first rising edge after i_RST_N deasserts.

Verification
REQ-034 Single: REQ0 DV, data 0x55, TX idle -> ACK0 1 cycle, next cycle o_TX_DV=1 with o_TX_DATA=0x55, o_GRANT=0.
REQ-035 Tie: both DV (0xA1, 0xB2) held, UART model completes each -> order 0xA1, 0xB2, 0xA1, 0xB2; each ACK exactly once per byte.
REQ-036 Spacing: i_TX_DONE 5 cycles after launch -> exactly one GAP cycle before next ACK; o_BUSY low ≥1 cycle between bytes.
REQ-037 Timeout: c_TIMEOUT_CYCLES=16, i_TX_DONE never -> o_TIMEOUT pulses 16 cycles after WAIT_DONE entry, then IDLE, pending REQ1 served next.
REQ-038 Busy TX: i_TX_ACTIVE high, REQ1 DV high -> no ACK until i_TX_ACTIVE falls, then ACK1 next edge.
REQ-039 Reset in WAIT_DONE: assert i_RST_N low -> all outputs reset values same cycle; after release with REQ0,REQ1 both high, REQ0 granted first.
